// File: rtl/student_fir_sample_sequencer.sv
// -----------------------------------------------------------------------------
// student_fir_sample_sequencer
//
// Controller for the FIR sample delay line kept in a dual-port RAM. Each
// accepted input sample is written into a circular buffer on port A. The
// block then reads NumTaps samples on port B, newest to oldest, and streams
// them to the MAC stage. After reset, or on request, the whole buffer is
// zero-filled so that taps not yet written read as 0.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised it stays high, with its data stable,
// until that transfer. Ready may rise or fall at any time. This holds for
// sample_valid_i/sample_ready_o and for tap_valid_o/tap_ready_i.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   clear_i                 buffer clear request, sampled in IDLE only
//   sample_i/_valid_i       input sample stream
//   sample_ready_o          input ready = (state == IDLE) && !clear_i
//   ram_ena_o/wea_o/addra_o/dia_o   port A (write side)
//   ram_enb_o/addrb_o       port B read request
//   ram_dob_i               port B data, one cycle after enb, held while enb=0
//   tap_data_o/_valid_o/_ready_i    tap stream to the MAC stage
//   tap_idx_o               tap index, 0 = newest sample
//   tap_first_o/_last_o     flags for idx 0 and idx NumTaps-1
//   busy_o                  high whenever the FSM is not in IDLE
//   dbg_state_o             current FSM state (CLEAR=0, IDLE=1, READ=2, DRAIN=3)
// -----------------------------------------------------------------------------
module student_fir_sample_sequencer #(
    parameter int AddrWidth = 10,
    parameter int DataSize  = 16,
    parameter int NumTaps   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [DataSize-1:0]  sample_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    output logic                 ram_ena_o,
    output logic                 ram_wea_o,
    output logic [AddrWidth-1:0] ram_addra_o,
    output logic [DataSize-1:0]  ram_dia_o,
    output logic                 ram_enb_o,
    output logic [AddrWidth-1:0] ram_addrb_o,
    input  logic [DataSize-1:0]  ram_dob_i,
    output logic [DataSize-1:0]  tap_data_o,
    output logic                 tap_valid_o,
    input  logic                 tap_ready_i,
    output logic [AddrWidth-1:0] tap_idx_o,
    output logic                 tap_first_o,
    output logic                 tap_last_o,
    output logic                 busy_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumTaps - 1);
    localparam logic [AddrWidth-1:0] One     = AddrWidth'(1);

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [AddrWidth-1:0] base_q;
    logic [AddrWidth-1:0] cnt_q;
    logic [AddrWidth-1:0] clr_ptr_q;
    logic                 tap_valid_q;
    logic [AddrWidth-1:0] tap_idx_q;
    logic                 tap_first_q;
    logic                 tap_last_q;

    logic accept;
    logic stall;
    logic last_tap;
    logic clr_done;

    assign sample_ready_o = (state_q == ST_IDLE) && !clear_i;
    assign accept         = sample_valid_i && sample_ready_o;
    // A tap still waiting at the output blocks the next read. Holding enb low
    // keeps the RAM output register, and therefore tap_data_o, stable.
    assign stall          = tap_valid_q && !tap_ready_i;
    assign last_tap       = (cnt_q == LastIdx);
    assign clr_done       = &clr_ptr_q;

    assign tap_data_o  = ram_dob_i;
    assign tap_valid_o = tap_valid_q;
    assign tap_idx_o   = tap_idx_q;
    assign tap_first_o = tap_first_q;
    assign tap_last_o  = tap_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        ram_ena_o   = 1'b0;
        ram_wea_o   = 1'b0;
        ram_addra_o = wr_ptr_q;
        ram_dia_o   = sample_i;
        ram_enb_o   = 1'b0;
        // Newest sample sits at base; older taps are found walking backwards.
        ram_addrb_o = base_q - cnt_q;
        case (state_q)
            ST_CLEAR: begin
                ram_ena_o   = 1'b1;
                ram_wea_o   = 1'b1;
                ram_addra_o = clr_ptr_q;
                ram_dia_o   = '0;
                if (clr_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                end else if (accept) begin
                    ram_ena_o = 1'b1;
                    ram_wea_o = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (!stall) begin
                    ram_enb_o = 1'b1;
                    if (last_tap) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tap_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            clr_ptr_q   <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_CLEAR: begin
                    // clr_ptr wraps back to 0 on the final write.
                    clr_ptr_q <= clr_ptr_q + One;
                    if (clr_done) wr_ptr_q <= '0;
                end
                ST_IDLE: begin
                    if (clear_i) begin
                        clr_ptr_q <= '0;
                    end else if (accept) begin
                        base_q   <= wr_ptr_q;
                        wr_ptr_q <= wr_ptr_q + One;
                        cnt_q    <= '0;
                    end
                end
                ST_READ: begin
                    if (!stall) begin
                        tap_valid_q <= 1'b1;
                        tap_idx_q   <= cnt_q;
                        tap_first_q <= (cnt_q == '0);
                        tap_last_q  <= last_tap;
                        if (!last_tap) cnt_q <= cnt_q + One;
                    end
                end
                ST_DRAIN: begin
                    if (tap_ready_i) tap_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_student_fir_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_student_fir_sample_sequencer
//
// Directed bench for the FIR sample sequencer with NumTaps=4 and a 1024-entry
// buffer. A small behavioural dual-port RAM closes the loop. Expected taps are
// hand-computed and queued as {idx, data}; a monitor pops one per transfer.
// -----------------------------------------------------------------------------
module tb_student_fir_sample_sequencer;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic          sample_valid_i = 1'b0;
    logic          sample_ready_o;
    logic          ram_ena_o, ram_wea_o;
    logic [AW-1:0] ram_addra_o;
    logic [DW-1:0] ram_dia_o;
    logic          ram_enb_o;
    logic [AW-1:0] ram_addrb_o;
    logic [DW-1:0] ram_dob_i;
    logic [DW-1:0] tap_data_o;
    logic          tap_valid_o;
    logic          tap_ready_i = 1'b1;
    logic [AW-1:0] tap_idx_o;
    logic          tap_first_o, tap_last_o;
    logic          busy_o;
    logic [1:0]    dbg_state_o;

    student_fir_sample_sequencer #(
        .AddrWidth(AW),
        .DataSize (DW),
        .NumTaps  (NT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o),
        .ram_ena_o     (ram_ena_o),
        .ram_wea_o     (ram_wea_o),
        .ram_addra_o   (ram_addra_o),
        .ram_dia_o     (ram_dia_o),
        .ram_enb_o     (ram_enb_o),
        .ram_addrb_o   (ram_addrb_o),
        .ram_dob_i     (ram_dob_i),
        .tap_data_o    (tap_data_o),
        .tap_valid_o   (tap_valid_o),
        .tap_ready_i   (tap_ready_i),
        .tap_idx_o     (tap_idx_o),
        .tap_first_o   (tap_first_o),
        .tap_last_o    (tap_last_o),
        .busy_o        (busy_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- RAM model: registered read, held while enb=0 ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_ena_o && ram_wea_o) mem[ram_addra_o] <= ram_dia_o;
        if (ram_enb_o) ram_dob_i <= mem[ram_addrb_o];
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_tap(input int idx, input int val);
        exp_q.push_back({AW'(idx), DW'(val)});
    endtask

    // Transfers are observed mid-low-phase, after stimulus has settled.
    always begin
        logic [AW+DW-1:0] e;
        @(negedge clk);
        #3;
        if (rst_ni && tap_valid_o && tap_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tap", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tap_data",  tap_data_o,  e[DW-1:0]);
                check("tap_idx",   tap_idx_o,   e[AW+DW-1:DW]);
                check("tap_first", tap_first_o, e[AW+DW-1:DW] == 0);
                check("tap_last",  tap_last_o,  e[AW+DW-1:DW] == AW'(NT - 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc, output int waited);
        waited = 0;
        #1;
        while (!sample_ready_o && waited < max_cyc) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!sample_ready_o) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Presents one sample in a cycle where ready is high; returns in cycle T+1.
    task automatic send(input logic [DW-1:0] v, input logic [AW-1:0] exp_addr);
        sample_valid_i = 1'b1;
        sample_i       = v;
        #1;
        check("wr_en",   {ram_ena_o, ram_wea_o}, 2'b11);
        check("wr_addr", ram_addra_o, exp_addr);
        check("wr_data", ram_dia_o, v);
        tick();
        sample_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        int w;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        wait_ready(1100, w);
        check("clear_len", w, 1024);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w;

        // Reset values, with a sample already pending.
        sample_valid_i = 1'b1;
        sample_i       = 16'h1234;
        tick();
        check("rst_busy",  busy_o, 1);
        check("rst_ready", sample_ready_o, 0);
        check("rst_valid", tap_valid_o, 0);
        check("rst_idx",   tap_idx_o, 0);
        check("rst_first", tap_first_o, 0);
        check("rst_last",  tap_last_o, 0);
        check("rst_state", dbg_state_o, 0);
        rst_ni = 1'b1;

        // CLEAR walks every address with zero data; ready rises at cycle 1024.
        for (int i = 0; i < 1024; i++) begin
            check("clr_addr",  ram_addra_o, i);
            check("clr_we",    {ram_ena_o, ram_wea_o}, 2'b11);
            check("clr_data",  ram_dia_o, 0);
            check("clr_ready", sample_ready_o, 0);
            tick();
        end
        check("first_ready", sample_ready_o, 1);
        check("idle_state",  dbg_state_o, 1);
        sample_valid_i = 1'b0;

        // Two back-to-back samples, no stall.
        push_tap(0, 16'h0011); push_tap(1, 0); push_tap(2, 0); push_tap(3, 0);
        send(16'h0011, 10'd0);
        wait_ready(20, w);
        check("ready_lat1", w, 5);
        push_tap(0, 16'h0022); push_tap(1, 16'h0011); push_tap(2, 0); push_tap(3, 0);
        send(16'h0022, 10'd1);
        check("rd0_en",    ram_enb_o, 1);
        check("rd0_addr",  ram_addrb_o, 1);
        check("t1_valid",  tap_valid_o, 0);
        tick();
        check("t2_valid",  tap_valid_o, 1);
        check("t2_idx",    tap_idx_o, 0);
        check("t2_data",   tap_data_o, 16'h0022);
        check("rd1_addr",  ram_addrb_o, 0);
        wait_ready(20, w);
        check("ready_lat2", w, 4);

        // clear_i wins over a same-cycle sample.
        clear_i        = 1'b1;
        sample_valid_i = 1'b1;
        sample_i       = 16'h0BAD;
        #1;
        check("clr_prio_ready", sample_ready_o, 0);
        check("clr_prio_ena",   ram_ena_o, 0);
        check("clr_prio_busy",  busy_o, 0);
        tick();
        clear_i        = 1'b0;
        sample_valid_i = 1'b0;
        check("clr_state", dbg_state_o, 0);
        check("clr_addr0", ram_addra_o, 0);
        wait_ready(1100, w);
        check("clear_len", w, 1024);
        push_tap(0, 16'h0ABC); push_tap(1, 0); push_tap(2, 0); push_tap(3, 0);
        send(16'h0ABC, 10'd0);
        wait_ready(20, w);

        // Pointer wrap: samples valued n written from address 0.
        do_clear();
        for (int n = 0; n < 1030; n++) begin
            for (int k = 0; k < NT; k++) push_tap(k, (n >= k) ? n - k : 0);
            send(DW'(n), AW'(n % 1024));
            if (n == 1025) begin
                check("wrap_rd0", ram_addrb_o, 1);
                tick();
                check("wrap_rd1", ram_addrb_o, 0);
                tick();
                check("wrap_rd2", ram_addrb_o, 1023);
                tick();
                check("wrap_rd3", ram_addrb_o, 1022);
            end
            wait_ready(20, w);
        end

        // Backpressure for 3 cycles while idx1 is presented.
        push_tap(0, 16'h0444); push_tap(1, 1029); push_tap(2, 1028); push_tap(3, 1027);
        send(16'h0444, 10'd6);
        tick();
        tick();
        tap_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_enb",   ram_enb_o, 0);
            check("bp_valid", tap_valid_o, 1);
            check("bp_idx",   tap_idx_o, 1);
            check("bp_data",  tap_data_o, 1029);
            tick();
        end
        tap_ready_i = 1'b1;
        wait_ready(30, w);

        // Reset during READ while idx2 is presented; idx2/idx3 are dropped.
        push_tap(0, 16'h0555); push_tap(1, 16'h0444);
        send(16'h0555, 10'd7);
        tick();
        tick();
        tick();
        tap_ready_i = 1'b0;
        #1;
        check("pre_rst_idx",   tap_idx_o, 2);
        check("pre_rst_valid", tap_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", tap_valid_o, 0);
        check("mid_rst_state", dbg_state_o, 0);
        check("mid_rst_ready", sample_ready_o, 0);
        check("mid_rst_addr",  ram_addra_o, 0);
        tick();
        tap_ready_i = 1'b1;
        rst_ni      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("reclr_addr", ram_addra_o, i);
            check("reclr_valid", tap_valid_o, 0);
            tick();
        end
        wait_ready(1100, w);
        check("reclr_len", w, 1020);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/student_fir_sample_sequencer.md
# student_fir_sample_sequencer

Controller for the FIR sample delay line held in `student_dpram_samples`. It accepts one input sample per handshake and writes it into a circular buffer on DPRAM port A. It then sequences `NumTaps` reads on port B, newest to oldest, and streams the samples to the MAC stage with a valid/ready handshake. Backpressure is absorbed by gating the RAM read enable; the RAM's registered output holds while the enable is low.

## Interface
- `AddrWidth`, 10: DPRAM address width; buffer depth is 2**AddrWidth; all pointer arithmetic is modulo 2**AddrWidth.
- `DataSize`, 16: sample width.
- `NumTaps`, 64: samples streamed per input sample; legal range 1..2**AddrWidth.
- Clocking and reset: one clock, `clk_i`; reset is asynchronous and active-low, `rst_ni`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  request a buffer clear; sampled only in IDLE.
- `sample_i`  in  DataSize  input sample.
- `sample_valid_i`  in  1  input sample valid.
- `sample_ready_o`  out  1  input ready, combinational: (state==IDLE) && !clear_i.
- `ram_ena_o`, `ram_wea_o`  out  1  port A enable and write enable.
- `ram_addra_o`  out  AddrWidth  port A address.
- `ram_dia_o`  out  DataSize  port A write data.
- `ram_enb_o`  out  1  port B read enable.
- `ram_addrb_o`  out  AddrWidth  port B address.
- `ram_dob_i`  in  DataSize  port B read data; valid 1 cycle after `enb`; held while `enb`=0.
- `tap_data_o`  out  DataSize  equals `ram_dob_i`.
- `tap_valid_o`  out  1  tap output valid (registered).
- `tap_ready_i`  in  1  downstream ready.
- `tap_idx_o`  out  AddrWidth  tap index; 0 is the newest sample (registered).
- `tap_first_o`, `tap_last_o`  out  1  flags for idx 0 and idx NumTaps-1 (registered).
- `busy_o`  out  1  high whenever state!=IDLE.

## Operation
- States: CLEAR, IDLE, READ, DRAIN. Reset enters CLEAR.
- Registers: `wr_ptr`, `base`, `cnt`, `clr_ptr`, and the tap output registers.
- CLEAR:
  - Each cycle: ena=wea=1, addra=clr_ptr, dia=0, then clr_ptr++.
  - After writing address 2**AddrWidth-1: wr_ptr←0 and go to IDLE.
  - Lasts exactly 2**AddrWidth cycles.
- IDLE, with clear_i=1:
  - Go to CLEAR with clr_ptr←0.
  - clear_i takes priority over a same-cycle sample, which is not accepted (ready=0).
- IDLE, on handshake (valid && ready):
  - Same cycle: ena=wea=1, addra=wr_ptr, dia=sample_i.
  - Registered: base←wr_ptr, wr_ptr←wr_ptr+1, cnt←0, go to READ.
- READ, stall definition: stall = tap_valid_o && !tap_ready_i.
- READ, not stalled:
  - enb=1, addrb=base−cnt (mod 2**AddrWidth).
  - Registered: tap_valid_o←1, tap_idx_o←cnt, tap_first_o←(cnt==0), tap_last_o←(cnt==NumTaps−1).
  - If cnt==NumTaps−1, go to DRAIN; otherwise cnt++.
- READ, stalled: enb=0; cnt and all tap registers hold. `tap_data_o` stays stable because the RAM output holds.
- DRAIN: when tap_ready_i=1, tap_valid_o←0 and go to IDLE. Otherwise hold.
- Port A is idle (ena=0) in READ and DRAIN. Port B is idle (enb=0) in CLEAR, IDLE and DRAIN.
- Before 2**AddrWidth samples have been written, unwritten taps read 0 because of the clear.

## Timing
- Reset values of outputs:
  - state=CLEAR, so busy_o=1 and sample_ready_o=0.
  - tap_valid_o, tap_first_o, tap_last_o, tap_idx_o = 0.
  - Internal wr_ptr, clr_ptr, cnt, base = 0.
  - tap_data_o is not defined by this block; it is the RAM output.
- Reset asserted mid-operation: all state is cleared asynchronously and the block re-enters CLEAR. In-flight taps are dropped.
- First ready after reset: cycle 2**AddrWidth.
- Sample latency with no stall:
  - Sample accepted at cycle T.
  - First read at T+1.
  - tap idx0 valid at T+2; it is the sample written at T.
  - idx NumTaps−1 valid at T+1+NumTaps.
  - Back in IDLE at T+2+NumTaps.
- Throughput: one sample per NumTaps+2 cycles.
- Write-then-read ordering: the write at T and the read of the same address at T+1 are never in the same cycle, so read-first collision cannot occur.
- Every tap transfers exactly once; no tap is duplicated or lost under any tap_ready_i pattern.

## Test plan
- Reset, then hold sample_valid_i: sample_ready_o stays 0 for 1024 cycles while addra walks 0..1023 with dia=0. Ready rises at cycle 1024.
- NumTaps=4, no stall; send 0x0011 then 0x0022 (the second as soon as ready returns): the second burst gives tap_data 0x0022, 0x0011, 0x0000, 0x0000 at T+2..T+5, with first on idx0, last on idx3 and ready again at T+6.
- Pointer wrap: send 1030 samples valued n: the burst for the last sample gives 1029, 1028, 1027, 1026. Write address for sample 1024 is 0; for the sample valued 1025, the reads are at addresses 1, 0, 1023, 1022.
- Backpressure: drop tap_ready_i for 3 cycles after idx1 is presented: ram_enb_o=0 and tap_data_o/tap_idx_o are held for those cycles. Sequence continues with idx2, with no duplicate or missing tap.
- clear_i and sample_valid_i asserted together in IDLE: no sample is accepted, CLEAR runs for 1024 cycles, and the next burst returns the new sample followed by zeros.
- Reset asserted during READ at idx2: tap_valid_o drops immediately and CLEAR restarts from address 0.
